// File: rtl/apb_cmd_master5_if.sv
// Command/response and APB signal bundle for apb_cmd_master5.
// master = initiator view, slave = command source plus APB target view.
interface apb_cmd_master5_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req_valid5;
  logic              req_ready5;
  logic              req_write5;
  logic [ADDR_W-1:0] req_addr5;
  logic [DATA_W-1:0] req_wdata5;
  logic              rsp_valid5;
  logic              rsp_ready5;
  logic [DATA_W-1:0] rsp_rdata5;
  logic              rsp_err5;
  logic              psel5;
  logic              penable5;
  logic              pwrite5;
  logic [ADDR_W-1:0] paddr5;
  logic [DATA_W-1:0] pwdata5;
  logic [DATA_W-1:0] prdata5;
  logic              pready5;
  logic              pslverr5;

  modport master (
    input  req_valid5, req_write5, req_addr5, req_wdata5,
    input  rsp_ready5, prdata5, pready5, pslverr5,
    output req_ready5, rsp_valid5, rsp_rdata5, rsp_err5,
    output psel5, penable5, pwrite5, paddr5, pwdata5
  );

  modport slave (
    output req_valid5, req_write5, req_addr5, req_wdata5,
    output rsp_ready5, prdata5, pready5, pslverr5,
    input  req_ready5, rsp_valid5, rsp_rdata5, rsp_err5,
    input  psel5, penable5, pwrite5, paddr5, pwdata5
  );
endinterface

// File: rtl/apb_cmd_master5.sv
// Single-outstanding APB initiator driven by a valid/ready command port.
// APB_CMD_PREADY_EN enables pready5/pslverr5 handling and the ACCESS timeout.
module apb_cmd_master5 #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               pclk5,
  input logic               p_reset5,
  apb_cmd_master5_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e            state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              done;
  logic              cpl_err;

`ifdef APB_CMD_PREADY_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;

  always_comb begin
    tmo   = 1'b0;
    cnt_d = cnt_q;
    if (TIMEOUT > 0)
      tmo = (state_q == ACCESS) && !bus.pready5 &&
            (cnt_q == CW'(TIMEOUT - 1));
    if (state_q == SETUP)
      cnt_d = '0;
    else if (state_q == ACCESS && !bus.pready5)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge pclk5) begin
    if (p_reset5) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done    = bus.pready5 | tmo;
  assign cpl_err = bus.pready5 ? bus.pslverr5 : 1'b1;
`else
  // APB2 targets have no pready: every ACCESS cycle completes.
  localparam int unused_timeout = TIMEOUT;
  logic unused_apb3;
  assign unused_apb3 = bus.pready5 ^ bus.pslverr5;
  assign done        = 1'b1;
  assign cpl_err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid5) begin
          pwrite_d = bus.req_write5;
          paddr_d  = bus.req_addr5;
          pwdata_d = bus.req_wdata5;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          rdata_d = (!pwrite_q && !cpl_err) ? bus.prdata5 : '0;
          err_d   = cpl_err;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready5) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk5) begin
    if (p_reset5) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready5 = (state_q == IDLE) && !p_reset5;
  assign bus.rsp_valid5 = (state_q == RESP);
  assign bus.rsp_rdata5 = rdata_q;
  assign bus.rsp_err5   = err_q;
  assign bus.psel5      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable5   = (state_q == ACCESS);
  assign bus.pwrite5    = pwrite_q;
  assign bus.paddr5     = paddr_q;
  assign bus.pwdata5    = pwdata_q;
endmodule

// File: tb/tb_apb_cmd_master5.sv
// Directed vector bench for apb_cmd_master5 (APB2 default, APB3 when
// APB_CMD_PREADY_EN is defined).
module tb_apb_cmd_master5;
  logic pclk5 = 1'b0;
  logic p_reset5;
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_cmd_master5_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  apb_cmd_master5 #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk5    (pclk5),
    .p_reset5 (p_reset5),
    .bus      (bus)
  );

  always #5 pclk5 = ~pclk5;

  typedef struct {
    logic        write;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk5);
    #1;
  endtask

  task automatic issue(input logic w, input logic [6:0] a,
                       input logic [31:0] d);
    bus.req_valid5 = 1'b1;
    bus.req_write5 = w;
    bus.req_addr5  = a;
    bus.req_wdata5 = d;
    chk("accept_ready", {31'd0, bus.req_ready5}, 32'd1);
    step();
    bus.req_valid5 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (bus.req_ready5) break;
      step();
    end
    chk("idle_reached", {31'd0, bus.req_ready5}, 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    bus.rsp_ready5 = 1'b1;
    bus.prdata5    = v.prdata;
    issue(v.write, v.addr, v.wdata);
    chk("setup_psel", {31'd0, bus.psel5}, 32'd1);
    chk("setup_pen", {31'd0, bus.penable5}, 32'd0);
    chk("setup_rdy", {31'd0, bus.req_ready5}, 32'd0);
    chk("setup_paddr", {25'd0, bus.paddr5}, {25'd0, v.addr});
    chk("setup_pwrite", {31'd0, bus.pwrite5}, {31'd0, v.write});
    chk("setup_pwdata", bus.pwdata5, v.wdata);
    step();
    chk("acc_psel", {31'd0, bus.psel5}, 32'd1);
    chk("acc_pen", {31'd0, bus.penable5}, 32'd1);
    chk("acc_paddr", {25'd0, bus.paddr5}, {25'd0, v.addr});
    chk("acc_pwdata", bus.pwdata5, v.wdata);
    step();
    chk("rsp_valid", {31'd0, bus.rsp_valid5}, 32'd1);
    chk("rsp_psel", {31'd0, bus.psel5}, 32'd0);
    chk("rsp_rdata", bus.rsp_rdata5, v.exp_rdata);
    chk("rsp_err", {31'd0, bus.rsp_err5}, {31'd0, v.exp_err});
    step();
    chk("post_valid", {31'd0, bus.rsp_valid5}, 32'd0);
    chk("post_ready", {31'd0, bus.req_ready5}, 32'd1);
  endtask

  initial begin
    int t0, t1, nacc, n;

    vecs[0] = '{1'b1, 7'h14, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 7'h08, 32'h11111111, 32'h12345678, 32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 7'h7F, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{1'b1, 7'h00, 32'h0, 32'h87654321, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 7'h7F, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 7'h00, 32'h0, 32'h0, 32'h0, 1'b0};

    p_reset5       = 1'b1;
    bus.req_valid5 = 1'b0;
    bus.req_write5 = 1'b0;
    bus.req_addr5  = '0;
    bus.req_wdata5 = '0;
    bus.rsp_ready5 = 1'b1;
    bus.prdata5    = '0;
    bus.pready5    = 1'b1;
    bus.pslverr5   = 1'b0;

    step();
    step();
    chk("rst_ready", {31'd0, bus.req_ready5}, 32'd0);
    chk("rst_psel", {31'd0, bus.psel5}, 32'd0);
    chk("rst_pen", {31'd0, bus.penable5}, 32'd0);
    chk("rst_valid", {31'd0, bus.rsp_valid5}, 32'd0);
    chk("rst_paddr", {25'd0, bus.paddr5}, 32'd0);
    chk("rst_pwdata", bus.pwdata5, 32'd0);
    chk("rst_rdata", bus.rsp_rdata5, 32'd0);
    p_reset5 = 1'b0;
    step();
    chk("rst_ready_after", {31'd0, bus.req_ready5}, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // back-to-back spacing with rsp_ready5 held high
    bus.rsp_ready5 = 1'b1;
    bus.prdata5    = 32'h12345678;
    bus.req_valid5 = 1'b1;
    bus.req_write5 = 1'b0;
    bus.req_addr5  = 7'h08;
    nacc = 0;
    t0 = 0;
    t1 = 0;
    for (int c = 0; c < 20 && nacc < 2; c++) begin
      if (bus.req_ready5) begin
        if (nacc == 0) t0 = c;
        else           t1 = c;
        nacc++;
      end
      step();
    end
    bus.req_valid5 = 1'b0;
    chk("b2b_accepts", nacc, 32'd2);
    chk("b2b_spacing", t1 - t0, 32'd4);
    wait_idle();

    // backpressure in RESP
    bus.rsp_ready5 = 1'b0;
    bus.prdata5    = 32'hCAFEF00D;
    issue(1'b0, 7'h08, 32'h0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, bus.rsp_valid5}, 32'd1);
      chk("bp_rdata", bus.rsp_rdata5, 32'hCAFEF00D);
      chk("bp_err", {31'd0, bus.rsp_err5}, 32'd0);
      chk("bp_ready", {31'd0, bus.req_ready5}, 32'd0);
      chk("bp_psel", {31'd0, bus.psel5}, 32'd0);
      bus.prdata5 = 32'h0BAD0BAD;
      if (i < 4) step();
    end
    bus.rsp_ready5 = 1'b1;
    step();
    chk("bp_release", {31'd0, bus.rsp_valid5}, 32'd0);

    // reset during ACCESS
`ifdef APB_CMD_PREADY_EN
    bus.pready5 = 1'b0;
`endif
    issue(1'b1, 7'h33, 32'h55AA55AA);
    step();
    chk("mr_in_access", {31'd0, bus.penable5}, 32'd1);
    p_reset5 = 1'b1;
    step();
    chk("mr_psel", {31'd0, bus.psel5}, 32'd0);
    chk("mr_pen", {31'd0, bus.penable5}, 32'd0);
    chk("mr_valid", {31'd0, bus.rsp_valid5}, 32'd0);
    chk("mr_paddr", {25'd0, bus.paddr5}, 32'd0);
    p_reset5    = 1'b0;
    bus.pready5 = 1'b1;
    step();
    chk("mr_ready_after", {31'd0, bus.req_ready5}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mr_no_rsp", {31'd0, bus.rsp_valid5}, 32'd0);
      step();
    end

`ifdef APB_CMD_PREADY_EN
    // 3 wait states then slave error
    bus.prdata5  = 32'h77777777;
    bus.pready5  = 1'b0;
    bus.pslverr5 = 1'b0;
    issue(1'b0, 7'h08, 32'h0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (!bus.penable5) break;
      n++;
      if (n == 4) begin
        bus.pready5  = 1'b1;
        bus.pslverr5 = 1'b1;
      end
    end
    chk("ws_access_cycles", n, 32'd4);
    chk("ws_valid", {31'd0, bus.rsp_valid5}, 32'd1);
    chk("ws_err", {31'd0, bus.rsp_err5}, 32'd1);
    chk("ws_rdata", bus.rsp_rdata5, 32'd0);
    bus.pslverr5 = 1'b0;
    step();
    wait_idle();

    // pready5 stuck low -> timeout
    bus.pready5 = 1'b0;
    issue(1'b0, 7'h10, 32'h0);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (!bus.penable5) break;
      n++;
    end
    chk("to_access_cycles", n, 32'd16);
    chk("to_valid", {31'd0, bus.rsp_valid5}, 32'd1);
    chk("to_err", {31'd0, bus.rsp_err5}, 32'd1);
    chk("to_rdata", bus.rsp_rdata5, 32'd0);
    bus.pready5 = 1'b1;
    step();
    wait_idle();
`else
    // APB2 ignores pready5/pslverr5
    bus.pready5  = 1'b0;
    bus.pslverr5 = 1'b1;
    run_txn('{1'b0, 7'h2A, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0});
    bus.pready5  = 1'b1;
    bus.pslverr5 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master5.md
# apb_cmd_master5

APB initiator that turns a simple valid/ready command interface into single APB read/write transfers, with one transfer outstanding at a time. It is the driving end of the bus that feeds APB register targets such as the address lookup table in the APB subsystem. It lets a local controller or test sequencer program and read those blocks without handling APB phasing itself.

## Interface
- ADDR_W, 7, width of req_addr5/paddr5
- DATA_W, 32, width of the write/read data buses
- TIMEOUT, 16, ACCESS-phase cycles without pready5 before forced error completion; 0 disables the timeout
- pclk5  in  1  clock, all logic on rising edge
- p_reset5  in  1  reset, synchronous, active-high
- req_valid5  in  1  command present
- req_ready5  out  1  command accepted when req_valid5 & req_ready5
- req_write5  in  1  1 = write, 0 = read
- req_addr5  in  ADDR_W  target address
- req_wdata5  in  DATA_W  write data
- rsp_valid5  out  1  completion present
- rsp_ready5  in  1  completion consumed when rsp_valid5 & rsp_ready5
- rsp_rdata5  out  DATA_W  read data; 0 for writes and errors
- rsp_err5  out  1  pslverr5 or timeout
- psel5  out  1  APB select
- penable5  out  1  APB enable
- pwrite5  out  1  APB direction
- paddr5  out  ADDR_W  APB address
- pwdata5  out  DATA_W  APB write data
- prdata5  in  DATA_W  APB read data
- pready5  in  1  APB ready; used only with APB_CMD_PREADY_EN
- pslverr5  in  1  APB slave error; used only with APB_CMD_PREADY_EN

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready5=1. On accept, register write/addr/wdata into the APB output registers and go to SETUP.
- SETUP: psel5=1, penable5=0. Always go to ACCESS next cycle.
- ACCESS: psel5=1, penable5=1. The transfer completes on a cycle with the completion condition (see Configuration).
  - On completion, capture prdata5 (reads only, else 0) and rsp_err5, then go to RESP.
- Timeout, active when TIMEOUT>0 and the macro is defined: the wait counter clears on entry to ACCESS and increments each ACCESS cycle without pready5. When the counter reaches TIMEOUT-1 without pready5, complete with rsp_err5=1 and rsp_rdata5=0.
- Error on a read: rsp_rdata5=0.
- RESP: psel5=0, penable5=0, rsp_valid5=1. rsp_rdata5 and rsp_err5 are held stable until rsp_ready5, then go to IDLE.
- req_ready5=0 in SETUP, ACCESS and RESP. Commands are never dropped or queued.
- paddr5, pwrite5 and pwdata5 are stable from SETUP through the last ACCESS cycle. They keep their last value outside a transfer.

## Timing
- Reset values: state IDLE, req_ready5=0 during reset and 1 the first cycle after, rsp_valid5=0, rsp_rdata5=0, rsp_err5=0, psel5=0, penable5=0, pwrite5=0, paddr5=0, pwdata5=0, wait counter 0.
- Accept at edge N → SETUP visible in cycle N+1 → ACCESS in N+2.
- Zero-wait completion → rsp_valid5 in N+3.
- Each wait state adds one cycle.
- Minimum command-to-command spacing with rsp_ready5 held high: 4 cycles.
- Reset asserted mid-transfer: at the next edge, all outputs return to reset values and the transfer is abandoned with no response.
- rsp_ready5 held high before rsp_valid5 rises: the response is consumed in its first RESP cycle.

## Configuration
- APB_CMD_PREADY_EN defined (APB3 mode): completion = pready5 in ACCESS, rsp_err5 = pslverr5 at completion, timeout active.
- APB_CMD_PREADY_EN not defined (APB2 mode): completion occurs on the first ACCESS cycle. pready5 and pslverr5 are ignored, rsp_err5 is always 0, the timeout logic is absent, and TIMEOUT has no effect. This mode is required for targets without pready, such as the lookup table.

## Test plan
- Write in APB2 mode: addr 0x14, data 0xDEADBEEF → psel5=1 for 2 cycles, penable5=1 only in the 2nd, pwrite5=1, paddr5=0x14, pwdata5=0xDEADBEEF; rsp_valid5 three cycles after accept, rsp_err5=0, rsp_rdata5=0.
- Read in APB2 mode: addr 0x08, slave returns 0x12345678 → rsp_rdata5=0x12345678; with rsp_ready5 held high, the next command is accepted 4 cycles after the first.
- Read in APB3 mode with pready5 low for 3 cycles and pslverr5=1 at completion → 4 ACCESS cycles, rsp_err5=1, rsp_rdata5=0.
- Timeout in APB3 mode with TIMEOUT=16 and pready5 stuck low → exactly 16 ACCESS cycles, then RESP with rsp_err5=1.
- Backpressure: hold rsp_ready5=0 for 5 cycles in RESP → rsp_valid5, rsp_rdata5 and rsp_err5 are stable, req_ready5=0, psel5=0 throughout.
- Reset: assert p_reset5 during ACCESS → next cycle psel5=0, penable5=0, rsp_valid5=0; no response is issued, and req_ready5=1 the cycle after reset deasserts.
